led_scan_controller: RTL and testbench

- Time-multiplexed scan engine for the 8-digit common-anode 7-segment display.
- Holds a double-buffered 8-digit hex value and steps a 3-bit digit index through the digits at a programmable rate.
- Drives the active-low segment pattern for the selected digit.
- `index` feeds the downstream `choice_digital_led` decoder, which turns it into the active-low digit-select bitmap.

---
 rtl/led_scan_controller.sv | 175 +++++++++++++++++
 tb/tb_led_scan_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_controller
// Purpose  : Time-multiplexed scan engine for an 8-digit common-anode
//            7-segment display. Holds a double-buffered hex value, steps a
//            digit index at a programmable rate and drives the active-low
//            segment pattern of the selected digit, with a blanking window
//            at the start of every digit slot to suppress ghosting.
// Ports    : clk        - system clock
//            rst        - synchronous reset, active-high
//            load       - write request, accepted when load && load_ready
//            load_data  - 8 hex nibbles, digit n = load_data[4n+3:4n]
//            load_dp    - decimal point per digit, 1 = lit
//            load_ready - shadow buffer free
//            index      - current digit number, index[0] carries the MSB
//            segments   - active-low, [6:0] = g..a, [7] = dp
//            digit_en   - high outside the blanking window
//            frame_tick - one-cycle pulse after index wraps to 0
// Options  : LED_SCAN_LEADING_ZERO_BLANK_EN - blank leading zero digits
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_controller #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    output logic        load_ready,
    output logic [2:0]  index,
    output logic [7:0]  segments,
    output logic        digit_en,
    output logic        frame_tick
);

    localparam int              c_presc_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_DIV - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
    localparam logic [c_presc_w-1:0] c_blank      = c_presc_w'(BLANK_CYCLES);
    localparam logic [2:0]      c_digit_last = 3'(NUM_DIGITS - 1);

    // Hex to segments, returned as {g,f,e,d,c,b,a}, 0 = lit.
    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        case (nib)
            4'h0: f_hex7 = 7'h40;
            4'h1: f_hex7 = 7'h79;
            4'h2: f_hex7 = 7'h24;
            4'h3: f_hex7 = 7'h30;
            4'h4: f_hex7 = 7'h19;
            4'h5: f_hex7 = 7'h12;
            4'h6: f_hex7 = 7'h02;
            4'h7: f_hex7 = 7'h78;
            4'h8: f_hex7 = 7'h00;
            4'h9: f_hex7 = 7'h10;
            4'hA: f_hex7 = 7'h08;
            4'hB: f_hex7 = 7'h03;
            4'hC: f_hex7 = 7'h46;
            4'hD: f_hex7 = 7'h21;
            4'hE: f_hex7 = 7'h06;
            default: f_hex7 = 7'h0E;
        endcase
    endfunction

    logic [c_presc_w-1:0] r_presc;
    logic [2:0]           r_digit;
    logic [31:0]          r_act_data;
    logic [7:0]           r_act_dp;
    logic [31:0]          r_shd_data;
    logic [7:0]           r_shd_dp;
    logic                 r_load_ready;
    logic [7:0]           r_segments;
    logic                 r_digit_en;
    logic                 r_frame_tick;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic                 w_transfer;
    logic                 w_accept;
    logic [c_presc_w-1:0] w_presc_nxt;
    logic [2:0]           w_digit_nxt;
    logic [31:0]          w_act_data_nxt;
    logic [7:0]           w_act_dp_nxt;
    logic [3:0]           w_nib;
    logic [7:0]           w_seg_lit;
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
    logic                 w_lz_run;
    logic                 w_lz_blank;
`endif

    // Next-state values feed the output registers directly so that segments
    // and digit_en line up with the prescaler/index they belong to.
    always_comb begin
        w_slot_end     = (r_presc == c_presc_last);
        w_frame_end    = w_slot_end && (r_digit == c_digit_last);
        // Shadow is pending exactly when load_ready is low.
        w_transfer     = w_frame_end && !r_load_ready;
        w_accept       = load && r_load_ready;
        w_presc_nxt    = w_slot_end ? '0 : r_presc + c_presc_one;
        w_digit_nxt    = r_digit;
        if (w_slot_end) begin
            w_digit_nxt = (r_digit == c_digit_last) ? 3'd0 : r_digit + 3'd1;
        end
        w_act_data_nxt = w_transfer ? r_shd_data : r_act_data;
        w_act_dp_nxt   = w_transfer ? r_shd_dp   : r_act_dp;
        w_nib          = w_act_data_nxt[{w_digit_nxt, 2'b00} +: 4];
        w_seg_lit      = {~w_act_dp_nxt[w_digit_nxt], f_hex7(w_nib)};
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; the run stays set while every digit
        // at or above the current one is an unlit zero. Digit 0 is excluded.
        w_lz_run   = 1'b1;
        w_lz_blank = 1'b0;
        for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
            w_lz_run = w_lz_run && (w_act_data_nxt[4*n +: 4] == 4'd0)
                       && !w_act_dp_nxt[n];
            if (w_digit_nxt == 3'(n)) begin
                w_lz_blank = w_lz_run;
            end
        end
        if (w_lz_blank) begin
            w_seg_lit = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_digit      <= 3'd0;
            r_act_data   <= 32'd0;
            r_act_dp     <= 8'd0;
            r_shd_data   <= 32'd0;
            r_shd_dp     <= 8'd0;
            r_load_ready <= 1'b1;
            r_segments   <= 8'hFF;
            r_digit_en   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_digit      <= w_digit_nxt;
            r_act_data   <= w_act_data_nxt;
            r_act_dp     <= w_act_dp_nxt;
            if (w_accept) begin
                r_shd_data <= load_data;
                r_shd_dp   <= load_dp;
            end
            // Transfer and accept are exclusive: one needs a pending shadow,
            // the other a free one.
            if (w_transfer) begin
                r_load_ready <= 1'b1;
            end else if (w_accept) begin
                r_load_ready <= 1'b0;
            end
            r_frame_tick <= w_frame_end;
            if (w_presc_nxt < c_blank) begin
                r_segments <= 8'hFF;
                r_digit_en <= 1'b0;
            end else begin
                r_segments <= w_seg_lit;
                r_digit_en <= 1'b1;
            end
        end
    end

    assign load_ready = r_load_ready;
    // Downstream decoder expects the digit number MSB on index[0].
    assign index      = {r_digit[0], r_digit[1], r_digit[2]};
    assign segments   = r_segments;
    assign digit_en   = r_digit_en;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_controller
// Purpose  : Self-checking bench for led_scan_controller (CLK_DIV=4,
//            BLANK_CYCLES=1, NUM_DIGITS=8). A cycle model predicts every
//            output; predictions are queued as stimulus is applied and
//            compared once the DUT has clocked. Fixed display patterns are
//            checked from constant tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_scan_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] load_data = 32'd0;
    logic [7:0]  load_dp = 8'd0;
    logic        load_ready;
    logic [2:0]  index;
    logic [7:0]  segments;
    logic        digit_en;
    logic        frame_tick;

    always #5 clk = ~clk;

    led_scan_controller #(
        .CLK_DIV      (4),
        .BLANK_CYCLES (1),
        .NUM_DIGITS   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .index      (index),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [2:0] idx;
        logic [7:0] seg;
        logic       en;
        logic       ft;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic [2:0] digit;
        logic [7:0] seg_str;   // written left to right as a,b,c,d,e,f,g,dp
    } vec_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [6:0]  abc [16];     // segment patterns, MSB = a
    vec_t        tab_a [8];
    vec_t        tab_b [8];

    // model state
    int          m_presc;
    int          m_idx;
    logic [31:0] m_act, m_shd;
    logic [7:0]  m_adp, m_sdp;
    logic        m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] idx_num(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic logic [7:0] str2seg(input logic [7:0] s);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = s[7-k];
        return r;
    endfunction

    function automatic logic [7:0] model_seg(input int n);
        logic [6:0] pat;
        logic [7:0] r;
        logic       lz;
        pat = abc[m_act[4*n +: 4]];
        for (int k = 0; k < 7; k++) r[k] = pat[6-k];
        r[7] = ~m_adp[n];
        lz = (n > 0);
        for (int m = n; m < 8; m++) begin
            if (m_act[4*m +: 4] != 4'd0 || m_adp[m]) lz = 1'b0;
        end
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
        if (lz) r = 8'hFF;
`endif
        return r;
    endfunction

    task automatic model_step(output exp_t e);
        logic wrap, fe;
        if (rst) begin
            m_presc = 0; m_idx = 0;
            m_act = 0; m_adp = 0; m_shd = 0; m_sdp = 0;
            m_rdy = 1'b1;
            e.ft = 1'b0;
        end else begin
            wrap = (m_presc == 3);
            fe   = wrap && (m_idx == 7);
            if (fe && !m_rdy) begin
                m_act = m_shd; m_adp = m_sdp; m_rdy = 1'b1;
            end else if (load && m_rdy) begin
                m_shd = load_data; m_sdp = load_dp; m_rdy = 1'b0;
            end
            m_presc = wrap ? 0 : m_presc + 1;
            if (wrap) m_idx = (m_idx == 7) ? 0 : m_idx + 1;
            e.ft = fe;
        end
        e.idx = 3'(m_idx);
        e.rdy = m_rdy;
        if (rst || m_presc < 1) begin
            e.seg = 8'hFF; e.en = 1'b0;
        end else begin
            e.seg = model_seg(m_idx); e.en = 1'b1;
        end
    endtask

    // Apply inputs for one clock, queue the prediction, compare after the edge.
    task automatic step(input logic r, input logic l, input logic [31:0] d, input logic [7:0] p);
        exp_t e;
        rst = r; load = l; load_data = d; load_dp = p;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_index",      32'(idx_num(index)), 32'(e.idx));
            check("sb_segments",   32'(segments),       32'(e.seg));
            check("sb_digit_en",   32'(digit_en),       32'(e.en));
            check("sb_frame_tick", 32'(frame_tick),     32'(e.ft));
            check("sb_load_ready", 32'(load_ready),     32'(e.rdy));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    // Step until the model reaches a lit slot of digit d, then compare segments.
    task automatic check_digit(input string name, input vec_t v);
        int i;
        i = 0;
        while (!(m_idx == int'(v.digit) && m_presc != 0) && i < 64) begin
            idle(1);
            i++;
        end
        if (i >= 64) check({name, "_timeout"}, 32'd1, 32'd0);
        else         check(name, 32'(segments), 32'(str2seg(v.seg_str)));
    endtask

    initial begin
        int ft_count;
        int i;
        abc = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        tab_a = '{'{3'd0, 8'b00000010}, '{3'd1, 8'b10011111},
                  '{3'd2, 8'b00100101}, '{3'd3, 8'b00001101},
                  '{3'd4, 8'b10011001}, '{3'd5, 8'b01001001},
                  '{3'd6, 8'b01000001}, '{3'd7, 8'b00011111}};
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
        tab_b = '{'{3'd0, 8'b01001001}, '{3'd1, 8'b00000011},
                  '{3'd2, 8'b10011111}, '{3'd3, 8'b11111111},
                  '{3'd4, 8'b11111111}, '{3'd5, 8'b11111111},
                  '{3'd6, 8'b11111111}, '{3'd7, 8'b11111111}};
`else
        tab_b = '{'{3'd0, 8'b01001001}, '{3'd1, 8'b00000011},
                  '{3'd2, 8'b10011111}, '{3'd3, 8'b00000011},
                  '{3'd4, 8'b00000011}, '{3'd5, 8'b00000011},
                  '{3'd6, 8'b00000011}, '{3'd7, 8'b00000011}};
`endif

        // Reset state
        @(negedge clk);
        step(1'b1, 1'b0, 32'd0, 8'd0);
        step(1'b1, 1'b0, 32'd0, 8'd0);
        check("rst_index",      32'(idx_num(index)), 32'd0);
        check("rst_segments",   32'(segments),       32'hFF);
        check("rst_digit_en",   32'(digit_en),       32'd0);
        check("rst_frame_tick", 32'(frame_tick),     32'd0);
        check("rst_load_ready", 32'(load_ready),     32'd1);

        // Free-running scan: one frame tick in 40 cycles
        ft_count = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            ft_count += int'(frame_tick);
        end
        check("ft_count_40", 32'(ft_count), 32'd1);
        check("idle_ready",  32'(load_ready), 32'd1);

        // Load mid-frame, then an ignored second load
        step(1'b0, 1'b1, 32'h76543210, 8'h01);
        check("load_ready_drop", 32'(load_ready), 32'd0);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF);
        check("load_ignored_ready", 32'(load_ready), 32'd0);
        i = 0;
        while (!(m_idx == 0 && m_presc == 0) && i < 64) begin idle(1); i++; end
        check("wrap_blank_seg", 32'(segments),   32'hFF);
        check("wrap_blank_en",  32'(digit_en),   32'd0);
        check("wrap_ready",     32'(load_ready), 32'd1);
        check("wrap_tick",      32'(frame_tick), 32'd1);
        for (int k = 0; k < 8; k++) check_digit("disp_a", tab_a[k]);

        // Load on the exact wrap cycle: transfer one frame later
        i = 0;
        while (!(m_idx == 7 && m_presc == 3) && i < 64) begin idle(1); i++; end
        step(1'b0, 1'b1, 32'h00000105, 8'h00);
        check("wrapload_ready", 32'(load_ready), 32'd0);
        check("wrapload_tick",  32'(frame_tick), 32'd1);
        idle(31);
        check("wrapload_hold",  32'(load_ready), 32'd0);
        idle(1);
        check("wrapload_xfer",  32'(load_ready), 32'd1);
        for (int k = 0; k < 8; k++) check_digit("disp_b", tab_b[k]);

        // Reset mid-slot with a pending shadow
        step(1'b0, 1'b1, 32'hAAAAAAAA, 8'hFF);
        idle(2);
        step(1'b1, 1'b0, 32'd0, 8'd0);
        check("midrst_index", 32'(idx_num(index)), 32'd0);
        check("midrst_seg",   32'(segments),       32'hFF);
        check("midrst_ready", 32'(load_ready),     32'd1);
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
